// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial stage that feeds the
// serial sequence detectors.
package serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Widest word the serializer supports; helpers take words zero-extended to this.
    localparam int MAX_WIDTH = 32;

    // Bit presented on the serial output: top bit of the live word or bit 0.
    function automatic logic bit_sel(
        input logic [MAX_WIDTH-1:0] word,
        input logic                 msb_first,
        input logic [4:0]           msb_idx
    );
        logic b;
        if (msb_first) begin
            b = word[msb_idx];
        end else begin
            b = word[0];
        end
        return b;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Serializes WIDTH-bit words one bit per clock, with a one-word hold buffer so
// back-to-back words stream without an idle gap.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             x_out,
    output logic             x_valid,
    output logic             word_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [4:0]       MSB_IDX  = 5'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept_s;
    logic             last_adv_s;
    logic [WIDTH-1:0] sr_shift_s;

    // Handshake and output decode from registered state.
    always_comb begin
        load_ready = rst && !hold_full_q;
        accept_s   = load_valid && load_ready;
        last_adv_s = (state_q == SHIFT) && (cnt_q == {CNT_W{1'b0}}) && en;
        word_done  = last_adv_s;
        if (state_q == SHIFT) begin
            x_valid = 1'b1;
            x_out   = bit_sel(MAX_WIDTH'(sr_q), MSB_FIRST, MSB_IDX);
        end else begin
            x_valid = 1'b0;
            x_out   = IDLE_BIT;
        end
    end

    // One-position shift toward the bit that gets presented next.
    always_comb begin
        if (MSB_FIRST) begin
            sr_shift_s = {sr_q[WIDTH-2:0], 1'b0};
        end else begin
            sr_shift_s = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    // Next-state logic for the IDLE/SHIFT controller, shifter and hold buffer.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    sr_d    = load_data;
                    cnt_d   = CNT_LAST;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (en && (cnt_q != {CNT_W{1'b0}})) begin
                    sr_d  = sr_shift_s;
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (last_adv_s) begin
                    // Refill without a gap bit: the hold word wins, then a same-cycle accept.
                    if (hold_full_q) begin
                        sr_d        = hold_q;
                        cnt_d       = CNT_LAST;
                        hold_full_d = 1'b0;
                    end else if (accept_s) begin
                        sr_d  = load_data;
                        cnt_d = CNT_LAST;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    sr_d  = sr_q;
                    cnt_d = cnt_q;
                end
                if (accept_s && !last_adv_s) begin
                    hold_d      = load_data;
                    hold_full_d = 1'b1;
                end else begin
                    hold_d = hold_d;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= {WIDTH{1'b0}};
            hold_q      <= {WIDTH{1'b0}};
            hold_full_q <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized and directed bench for bit_serializer (WIDTH=4), with an MSB-first
// and an LSB-first instance checked against a word-queue reference model.
module tb_bit_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic [W-1:0] load_data_lsb;

    logic ready_m, x_m, valid_m, done_m;
    logic ready_l, x_l, valid_l, done_l;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: accepted words in order, plus position within the front word.
    logic [W-1:0] wq[$];
    int           idx = 0;
    logic         obs_x;
    logic         obs_valid;
    logic         obs_done;
    logic         obs_ready;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_data(load_data),
        .load_ready(ready_m), .x_out(x_m), .x_valid(valid_m), .word_done(done_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .en(en), .load_valid(load_valid), .load_data(load_data_lsb),
        .load_ready(ready_l), .x_out(x_l), .x_valid(valid_l), .word_done(done_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d[W-1-i];
        return r;
    endfunction

    // One clock: drive inputs, check both DUTs at the falling edge, advance the model.
    task automatic step(input logic r, input logic e, input logic v, input logic [W-1:0] d);
        logic exp_ready, exp_valid, exp_x, exp_done;
        logic [W-1:0] front;
        rst = r; en = e; load_valid = v; load_data = d; load_data_lsb = rev(d);
        @(negedge clk);
        exp_ready = r && (wq.size() < 2);
        exp_valid = (wq.size() > 0);
        front     = exp_valid ? wq[0] : '0;
        exp_x     = exp_valid ? front[W-1-idx] : 1'b0;
        exp_done  = exp_valid && (idx == W-1) && e;
        obs_x = x_m; obs_valid = valid_m; obs_done = done_m; obs_ready = ready_m;
        chk("ready",     32'(ready_m), 32'(exp_ready));
        chk("x_out",     32'(x_m),     32'(exp_x));
        chk("x_valid",   32'(valid_m), 32'(exp_valid));
        chk("word_done", 32'(done_m),  32'(exp_done));
        chk("lsb_ready", 32'(ready_l), 32'(exp_ready));
        chk("lsb_x_out", 32'(x_l),     32'(exp_x));
        chk("lsb_valid", 32'(valid_l), 32'(exp_valid));
        chk("lsb_done",  32'(done_l),  32'(exp_done));
        if (!r) begin
            wq.delete();
            idx = 0;
        end else begin
            if (e && wq.size() > 0) begin
                idx++;
                if (idx == W) begin
                    void'(wq.pop_front());
                    idx = 0;
                end
            end
            if (v && exp_ready) wq.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]   pat8;
        logic [W-1:0] pat;
        rst = 1'b0; en = 1'b1; load_valid = 1'b1; load_data = 4'hF; load_data_lsb = 4'hF;
        @(posedge clk);
        #1;

        // Reset held with load_valid high, then release.
        step(1'b0, 1'b1, 1'b1, 4'hF);
        step(1'b0, 1'b1, 1'b1, 4'hF);
        chk("rst_valid", 32'(obs_valid), 32'd0);
        chk("rst_ready", 32'(obs_ready), 32'd0);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        chk("rel_ready", 32'(obs_ready), 32'd1);

        // Single word.
        pat = 4'b1010;
        step(1'b1, 1'b1, 1'b1, pat);
        for (int i = 0; i < W; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'h0);
            chk("single_bit", 32'(obs_x), 32'(pat[W-1-i]));
            chk("single_done", 32'(obs_done), (i == W-1) ? 32'd1 : 32'd0);
        end
        step(1'b1, 1'b1, 1'b0, 4'h0);
        chk("single_idle", 32'(obs_valid), 32'd0);

        // Back-to-back words stream without a gap.
        pat8 = 8'b11000011;
        step(1'b1, 1'b1, 1'b1, 4'b1100);
        step(1'b1, 1'b1, 1'b1, 4'b0011);
        chk("b2b_bit0", 32'(obs_x), 32'(pat8[7]));
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'h0);
            chk("b2b_bit", 32'(obs_x), 32'(pat8[7-i]));
            chk("b2b_valid", 32'(obs_valid), 32'd1);
        end

        // en stall on bit 2 of 4'b1001.
        step(1'b1, 1'b1, 1'b1, 4'b1001);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'h0);
            chk("stall_hold", 32'(obs_x), 32'd0);
        end
        step(1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        chk("stall_last_nodone", 32'(obs_done), 32'd0);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        chk("stall_last_done", 32'(obs_done), 32'd1);

        // Reset mid-word with the hold buffer full.
        step(1'b1, 1'b1, 1'b1, 4'b1111);
        step(1'b1, 1'b1, 1'b1, 4'b0101);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 4'h0);
        chk("midrst_valid", 32'(obs_valid), 32'd0);
        pat = 4'b0110;
        step(1'b1, 1'b1, 1'b1, pat);
        for (int i = 0; i < W; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'h0);
            chk("post_rst_bit", 32'(obs_x), 32'(pat[W-1-i]));
        end

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 99) >= 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 4'($urandom));
        end
        for (int c = 0; c < 12; c++) step(1'b1, 1'b1, 1'b0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
